// File: rtl/window_centroid.sv
// ---------------------------------------------------------------------------
// window_centroid
//
// Scans a WIDTH x HEIGHT window buffer (3-bit pixel codes, row-major) once per
// request. It counts the pixels equal to a target code and reports the
// integer centroid of those pixels.
//
// Optional feature: define WINDOW_CENTROID_BBOX_EN to add the bounding-box
// outputs xmin/xmax/ymin/ymax.
//
// Ports
//   sysclk     in   1   clock; all state changes on the rising edge
//   reset      in   1   asynchronous, active-high reset
//   start      in   1   request one scan (accepted only while idle)
//   target     in   3   pixel code to match, sampled when start is accepted
//   rdaddr     out  16  window RAM read address
//   q          in   3   RAM read data, valid one cycle after rdaddr
//   busy       out  1   high from start acceptance until the done pulse
//   done       out  1   one-cycle pulse; results change in the same cycle
//   found      out  1   count >= MIN_COUNT
//   cx, cy     out  7   centroid column/row (truncated), 0 when !found
//   count      out  14  number of matching pixels
//   xmin..ymax out  7   bounding box of matches, 0 when !found (BBOX only)
//   dbg_state  out  3   current FSM state encoding
//
// Handshake: start is a request that is taken only in a cycle where busy is
// low. busy rises on the next edge. done pulses for exactly one cycle, and
// busy falls in that same cycle. A start asserted while busy is dropped and
// is not queued.
// ---------------------------------------------------------------------------
module window_centroid #(
    parameter int WIDTH     = 100,
    parameter int HEIGHT    = 100,
    parameter int MIN_COUNT = 16
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  target,
    output logic [15:0] rdaddr,
    input  logic [2:0]  q,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [6:0]  cx,
    output logic [6:0]  cy,
    output logic [13:0] count,
`ifdef WINDOW_CENTROID_BBOX_EN
    output logic [6:0]  xmin,
    output logic [6:0]  xmax,
    output logic [6:0]  ymin,
    output logic [6:0]  ymax,
`endif
    output logic [2:0]  dbg_state
);

    localparam logic [15:0] LAST_ADDR = 16'(WIDTH * HEIGHT - 1);
    localparam logic [6:0]  X_LAST    = 7'(WIDTH - 1);
    localparam logic [13:0] MIN_CNT   = 14'(MIN_COUNT);
    localparam logic [4:0]  DIV_LAST  = 5'd19;   // 20 quotient bits

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        DRAIN  = 3'd2,
        DIVIDE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // scan
    logic [15:0] r_rdaddr;
    logic [6:0]  r_x;
    logic [6:0]  r_y;
    logic [6:0]  r_dx;          // coordinates of the pixel now on q
    logic [6:0]  r_dy;
    logic        r_vld;         // q carries a real pixel this cycle
    logic [2:0]  r_target;

    // accumulators
    logic [13:0] r_count;
    logic [19:0] r_sum_x;
    logic [19:0] r_sum_y;

    // dividers: r_num_* is shifted out MSB-first and refilled with quotient bits
    logic [19:0] r_num_x;
    logic [19:0] r_num_y;
    logic [13:0] r_rem_x;
    logic [13:0] r_rem_y;
    logic [13:0] r_div_d;
    logic [4:0]  r_div_cnt;

    // results
    logic        r_busy;
    logic        r_done;
    logic        r_found;
    logic [6:0]  r_cx;
    logic [6:0]  r_cy;
    logic [13:0] r_count_out;

    // FSM strobes
    logic        w_start_ok;
    logic        w_acc_en;
    logic        w_load_div;
    logic        w_div_step;
    logic        w_publish;

    // datapath
    logic        w_match;
    logic [13:0] w_count_nxt;
    logic [19:0] w_sum_x_nxt;
    logic [19:0] w_sum_y_nxt;
    logic        w_found_nxt;
    logic        w_fin_found;
    logic [14:0] w_trial_x;
    logic [14:0] w_trial_y;
    logic        w_ge_x;
    logic        w_ge_y;
    logic [13:0] w_sub_x;
    logic [13:0] w_sub_y;
    logic [6:0]  w_qx;
    logic [6:0]  w_qy;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_acc_en    = 1'b0;
        w_load_div  = 1'b0;
        w_div_step  = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_acc_en = r_vld;
                if (r_rdaddr == LAST_ADDR) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The last pixel arrives now. The divider is loaded with the
                // final sums even when the result turns out invalid. That
                // load is harmless.
                w_acc_en    = 1'b1;
                w_load_div  = 1'b1;
                w_state_nxt = w_found_nxt ? DIVIDE : DONE;
            end
            DIVIDE: begin
                w_div_step = 1'b1;
                if (r_div_cnt == DIV_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_publish   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Accumulate / divide combinational terms
    // -----------------------------------------------------------------------
    always_comb begin
        w_match     = w_acc_en && (q == r_target);
        w_count_nxt = r_count + 14'(w_match);
        w_sum_x_nxt = r_sum_x + (w_match ? 20'(r_dx) : 20'd0);
        w_sum_y_nxt = r_sum_y + (w_match ? 20'(r_dy) : 20'd0);
        w_found_nxt = (w_count_nxt >= MIN_CNT);
        w_fin_found = (r_count >= MIN_CNT);

        // Restoring step. Because rem < divisor, the trial fits in 15 bits.
        // When the trial is >= divisor, the 14-bit modular subtraction
        // gives the exact remainder.
        w_trial_x = {r_rem_x, r_num_x[19]};
        w_trial_y = {r_rem_y, r_num_y[19]};
        w_ge_x    = (w_trial_x >= {1'b0, r_div_d});
        w_ge_y    = (w_trial_y >= {1'b0, r_div_d});
        w_sub_x   = w_trial_x[13:0] - r_div_d;
        w_sub_y   = w_trial_y[13:0] - r_div_d;

        // A centroid always lies inside the window. Saturation only guards
        // against parameter sets wider than the 7-bit outputs.
        w_qx = (|r_num_x[19:7]) ? 7'h7F : r_num_x[6:0];
        w_qy = (|r_num_y[19:7]) ? 7'h7F : r_num_y[6:0];
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rdaddr    <= 16'd0;
            r_x         <= 7'd0;
            r_y         <= 7'd0;
            r_dx        <= 7'd0;
            r_dy        <= 7'd0;
            r_vld       <= 1'b0;
            r_target    <= 3'd0;
            r_count     <= 14'd0;
            r_sum_x     <= 20'd0;
            r_sum_y     <= 20'd0;
            r_num_x     <= 20'd0;
            r_num_y     <= 20'd0;
            r_rem_x     <= 14'd0;
            r_rem_y     <= 14'd0;
            r_div_d     <= 14'd0;
            r_div_cnt   <= 5'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_cx        <= 7'd0;
            r_cy        <= 7'd0;
            r_count_out <= 14'd0;
        end else begin
            r_done <= w_publish;

            if (w_start_ok) begin
                r_target <= target;
                r_rdaddr <= 16'd0;
                r_x      <= 7'd0;
                r_y      <= 7'd0;
                r_vld    <= 1'b0;
                r_count  <= 14'd0;
                r_sum_x  <= 20'd0;
                r_sum_y  <= 20'd0;
                r_busy   <= 1'b1;
            end

            if (r_state == READ) begin
                // rdaddr parks on the last address. It does not run past it.
                if (r_rdaddr != LAST_ADDR) begin
                    r_rdaddr <= r_rdaddr + 16'd1;
                end
                if (r_x == X_LAST) begin
                    r_x <= 7'd0;
                    r_y <= r_y + 7'd1;
                end else begin
                    r_x <= r_x + 7'd1;
                end
                // q lags rdaddr by one cycle, so the coordinates lag with it
                r_dx  <= r_x;
                r_dy  <= r_y;
                r_vld <= 1'b1;
            end

            if (w_acc_en) begin
                r_count <= w_count_nxt;
                r_sum_x <= w_sum_x_nxt;
                r_sum_y <= w_sum_y_nxt;
            end

            if (w_load_div) begin
                r_num_x   <= w_sum_x_nxt;
                r_num_y   <= w_sum_y_nxt;
                r_rem_x   <= 14'd0;
                r_rem_y   <= 14'd0;
                r_div_d   <= w_count_nxt;
                r_div_cnt <= 5'd0;
            end

            if (w_div_step) begin
                r_rem_x   <= w_ge_x ? w_sub_x : w_trial_x[13:0];
                r_rem_y   <= w_ge_y ? w_sub_y : w_trial_y[13:0];
                r_num_x   <= {r_num_x[18:0], w_ge_x};
                r_num_y   <= {r_num_y[18:0], w_ge_y};
                r_div_cnt <= r_div_cnt + 5'd1;
            end

            if (w_publish) begin
                r_busy      <= 1'b0;
                r_found     <= w_fin_found;
                r_count_out <= r_count;
                r_cx        <= w_fin_found ? w_qx : 7'd0;
                r_cy        <= w_fin_found ? w_qy : 7'd0;
            end
        end
    end

`ifdef WINDOW_CENTROID_BBOX_EN
    // -----------------------------------------------------------------------
    // Bounding box: the minima start at all-ones so the first match wins
    // -----------------------------------------------------------------------
    logic [6:0] r_bx_min;
    logic [6:0] r_bx_max;
    logic [6:0] r_by_min;
    logic [6:0] r_by_max;
    logic [6:0] r_xmin;
    logic [6:0] r_xmax;
    logic [6:0] r_ymin;
    logic [6:0] r_ymax;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_bx_min <= 7'd0;
            r_bx_max <= 7'd0;
            r_by_min <= 7'd0;
            r_by_max <= 7'd0;
            r_xmin   <= 7'd0;
            r_xmax   <= 7'd0;
            r_ymin   <= 7'd0;
            r_ymax   <= 7'd0;
        end else begin
            if (w_start_ok) begin
                r_bx_min <= 7'h7F;
                r_bx_max <= 7'd0;
                r_by_min <= 7'h7F;
                r_by_max <= 7'd0;
            end
            if (w_match) begin
                if (r_dx < r_bx_min) r_bx_min <= r_dx;
                if (r_dx > r_bx_max) r_bx_max <= r_dx;
                if (r_dy < r_by_min) r_by_min <= r_dy;
                if (r_dy > r_by_max) r_by_max <= r_dy;
            end
            if (w_publish) begin
                r_xmin <= w_fin_found ? r_bx_min : 7'd0;
                r_xmax <= w_fin_found ? r_bx_max : 7'd0;
                r_ymin <= w_fin_found ? r_by_min : 7'd0;
                r_ymax <= w_fin_found ? r_by_max : 7'd0;
            end
        end
    end

    assign xmin = r_xmin;
    assign xmax = r_xmax;
    assign ymin = r_ymin;
    assign ymax = r_ymax;
`endif

    assign rdaddr    = r_rdaddr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign found     = r_found;
    assign cx        = r_cx;
    assign cy        = r_cy;
    assign count     = r_count_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_window_centroid.sv
// Self-checking bench for window_centroid (default 100x100, MIN_COUNT=16).
// A behavioural model scans the bench RAM array directly to predict each
// result. A compare process checks the outputs on every done pulse and on
// every idle cycle. Directed scenes also carry hand-computed literals.
module tb_window_centroid;

    localparam int W       = 100;
    localparam int H       = 100;
    localparam int N       = W * H;
    localparam int MINC    = 16;
    localparam int EW      = 57;
    localparam int LAT_MAX = N + 25;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  target;
    logic [15:0] rdaddr;
    logic [2:0]  q = 3'd0;
    logic        busy;
    logic        done;
    logic        found;
    logic [6:0]  cx;
    logic [6:0]  cy;
    logic [13:0] count;
    logic [2:0]  dbg_state;
`ifdef WINDOW_CENTROID_BBOX_EN
    logic [6:0]  xmin;
    logic [6:0]  xmax;
    logic [6:0]  ymin;
    logic [6:0]  ymax;
`endif

    int total = 0;
    int bad   = 0;
    int lat_found = -1;
    int lat_miss  = -1;

    logic [2:0]    mem [N];
    // packed expectation: {found, cx, cy, count, xmin, xmax, ymin, ymax}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] hold_exp = '0;

    window_centroid dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .start     (start),
        .target    (target),
        .rdaddr    (rdaddr),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .cx        (cx),
        .cy        (cy),
        .count     (count),
`ifdef WINDOW_CENTROID_BBOX_EN
        .xmin      (xmin),
        .xmax      (xmax),
        .ymin      (ymin),
        .ymax      (ymax),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / RAM ----------------
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) q <= mem[(int'(rdaddr) < N) ? int'(rdaddr) : 0];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Behavioural model: direct scan of the RAM contents
    function automatic logic [EW-1:0] model(input logic [2:0] tgt);
        int cnt = 0;
        int sx = 0;
        int sy = 0;
        int xmn = 127;
        int xmx = 0;
        int ymn = 127;
        int ymx = 0;
        int rx, ry;
        logic fnd;
        for (int a = 0; a < N; a++) begin
            if (mem[a] == tgt) begin
                rx = a % W;
                ry = a / W;
                cnt++;
                sx += rx;
                sy += ry;
                if (rx < xmn) xmn = rx;
                if (rx > xmx) xmx = rx;
                if (ry < ymn) ymn = ry;
                if (ry > ymx) ymx = ry;
            end
        end
        fnd = (cnt >= MINC);
        return {fnd, 7'(fnd ? sx / cnt : 0), 7'(fnd ? sy / cnt : 0), 14'(cnt),
                7'(fnd ? xmn : 0), 7'(fnd ? xmx : 0), 7'(fnd ? ymn : 0), 7'(fnd ? ymx : 0)};
    endfunction

    task automatic compare_outputs(input string tag, input logic [EW-1:0] e);
        check({tag, "_found"}, int'(found), int'(e[56]));
        check({tag, "_cx"},    int'(cx),    int'(e[55:49]));
        check({tag, "_cy"},    int'(cy),    int'(e[48:42]));
        check({tag, "_count"}, int'(count), int'(e[41:28]));
`ifdef WINDOW_CENTROID_BBOX_EN
        check({tag, "_xmin"},  int'(xmin),  int'(e[27:21]));
        check({tag, "_xmax"},  int'(xmax),  int'(e[20:14]));
        check({tag, "_ymin"},  int'(ymin),  int'(e[13:7]));
        check({tag, "_ymax"},  int'(ymax),  int'(e[6:0]));
`endif
    endtask

    // Compare process: results on done, held values on every idle cycle
    always @(negedge sysclk) begin
        if (reset) begin
            exp_q.delete();
            hold_exp = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                hold_exp = exp_q.pop_front();
                compare_outputs("result", hold_exp);
            end
        end else if (!busy) begin
            compare_outputs("hold", hold_exp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int a = 0; a < N; a++) mem[a] = 3'd0;
    endtask

    task automatic set_px(input int x, input int y, input logic [2:0] code);
        mem[y * W + x] = code;
    endtask

    task automatic start_scan(input logic [2:0] tgt, output logic [EW-1:0] e);
        @(negedge sysclk);
        #2;
        e = model(tgt);
        exp_q.push_back(e);
        start  = 1'b1;
        target = tgt;
        @(posedge sysclk);
        #1;
        start  = 1'b0;
        target = ~tgt;      // target must already be latched
    endtask

    task automatic wait_done(input string tag, input int pre, input bit exp_fnd);
        int cyc = pre;
        int max_addr = 0;
        bit seen = 1'b0;
        while (!seen && cyc < LAT_MAX + 5) begin
            @(negedge sysclk);
            cyc++;
            if (int'(rdaddr) > max_addr) max_addr = int'(rdaddr);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
            #2 reset = 1'b1;
            @(negedge sysclk);
            #2 reset = 1'b0;
        end else begin
            check({tag, "_latency_bound"}, int'(cyc <= LAT_MAX), 1);
            check({tag, "_max_rdaddr"}, max_addr, N - 1);
            if (exp_fnd) begin
                if (lat_found < 0) lat_found = cyc;
                else check({tag, "_latency_same"}, cyc, lat_found);
            end else begin
                if (lat_miss < 0) lat_miss = cyc;
                else check({tag, "_latency_same"}, cyc, lat_miss);
            end
            @(negedge sysclk);
            check({tag, "_done_one_cycle"}, int'(done), 0);
            check({tag, "_busy_low"}, int'(busy), 0);
        end
    endtask

    task automatic place_block();
        clear_mem();
        for (int y = 10; y <= 14; y++)
            for (int x = 40; x <= 44; x++)
                set_px(x, y, 3'd3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [EW-1:0] e;
        int  k;
        bit  reached;
        bit  saw_done;

        reset  = 1'b1;
        start  = 1'b0;
        target = 3'd0;
        clear_mem();

        repeat (3) @(negedge sysclk);
        check("rst_rdaddr", int'(rdaddr), 0);
        check("rst_busy",   int'(busy),   0);
        check("rst_done",   int'(done),   0);
        check("rst_found",  int'(found),  0);
        check("rst_cx",     int'(cx),     0);
        check("rst_cy",     int'(cy),     0);
        check("rst_count",  int'(count),  0);
`ifdef WINDOW_CENTROID_BBOX_EN
        check("rst_xmax",   int'(xmax),   0);
        check("rst_ymax",   int'(ymax),   0);
`endif
        #2 reset = 1'b0;
        repeat (2) @(negedge sysclk);

        // Scene 1: empty RAM, target 1
        start_scan(3'd1, e);
        wait_done("empty", 0, e[56]);
        check("empty_count_lit", int'(count), 0);
        check("empty_found_lit", int'(found), 0);
        check("empty_cx_lit",    int'(cx),    0);
        check("empty_cy_lit",    int'(cy),    0);

        // Scene 2: 5x5 block of code 3 at x=40..44, y=10..14
        place_block();
        start_scan(3'd3, e);
        check("model_block_count", int'(e[41:28]), 25);
        check("model_block_cx",    int'(e[55:49]), 42);
        wait_done("block", 0, e[56]);
        check("block_count_lit", int'(count), 25);
        check("block_cx_lit",    int'(cx),    42);
        check("block_cy_lit",    int'(cy),    12);
        check("block_found_lit", int'(found), 1);
`ifdef WINDOW_CENTROID_BBOX_EN
        check("block_xmin_lit", int'(xmin), 40);
        check("block_xmax_lit", int'(xmax), 44);
        check("block_ymin_lit", int'(ymin), 10);
        check("block_ymax_lit", int'(ymax), 14);
`endif

        // Scene 3: 10 isolated pixels of code 5 (below MIN_COUNT)
        clear_mem();
        for (int i = 0; i < 10; i++) mem[37 + i * 997] = 3'd5;
        start_scan(3'd5, e);
        wait_done("sparse", 0, e[56]);
        check("sparse_count_lit", int'(count), 10);
        check("sparse_found_lit", int'(found), 0);
        check("sparse_cx_lit",    int'(cx),    0);

        // Scene 4: corners plus 14-pixel cluster, target 7, code-6 noise
        clear_mem();
        set_px(0, 0, 3'd7);
        set_px(W - 1, H - 1, 3'd7);
        for (int y = 50; y <= 51; y++)
            for (int x = 48; x <= 54; x++)
                set_px(x, y, 3'd7);
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(N - 1, 0);
            if (mem[k] == 3'd0) mem[k] = 3'd6;
        end
        start_scan(3'd7, e);
        check("model_corner_cy", int'(e[48:42]), 50);
        wait_done("corner", 0, e[56]);
        check("corner_count_lit", int'(count), 16);
        check("corner_found_lit", int'(found), 1);
        check("corner_cx_lit",    int'(cx),    50);
        check("corner_cy_lit",    int'(cy),    50);
`ifdef WINDOW_CENTROID_BBOX_EN
        check("corner_xmin_lit", int'(xmin), 0);
        check("corner_xmax_lit", int'(xmax), 99);
`endif

        // Scene 5: drop one corner (count 15, just below MIN_COUNT) and
        // pulse start with target 0 mid-READ; that request must be ignored
        set_px(W - 1, H - 1, 3'd0);
        start_scan(3'd7, e);
        repeat (200) @(negedge sysclk);
        #2;
        start  = 1'b1;
        target = 3'd0;
        @(posedge sysclk);
        #1 start = 1'b0;
        wait_done("ignore_start", 200, e[56]);
        check("ignore_start_count_lit", int'(count), 15);
        check("ignore_start_found_lit", int'(found), 0);

        // Scene 6: reset at rdaddr=5000 aborts the scan with no done
        place_block();
        start_scan(3'd3, e);
        reached = 1'b0;
        for (int c = 0; c < N && !reached; c++) begin
            @(negedge sysclk);
            if (int'(rdaddr) == 5000) reached = 1'b1;
        end
        check("abort_reach_5000", int'(reached), 1);
        #2 reset = 1'b1;
        #1;
        check("abort_rdaddr", int'(rdaddr), 0);
        check("abort_busy",   int'(busy),   0);
        check("abort_done",   int'(done),   0);
        check("abort_found",  int'(found),  0);
        check("abort_count",  int'(count),  0);
        check("abort_cx",     int'(cx),     0);
        repeat (3) @(negedge sysclk);
        #2 reset = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge sysclk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", int'(saw_done), 0);

        start_scan(3'd3, e);
        wait_done("after_abort", 0, e[56]);
        check("after_abort_count_lit", int'(count), 25);
        check("after_abort_cx_lit",    int'(cx),    42);
        check("after_abort_cy_lit",    int'(cy),    12);

        repeat (3) @(negedge sysclk);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
